// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: result-select encoding and datapath constants.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// W-stage bundle, decode read ports and write-back outputs of the register file.
interface writeback_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic            RegWriteW;
  logic [AW-1:0]   RdW;
  logic [1:0]      ResultSrcW;
  logic [XLEN-1:0] ALUResultW;
  logic [XLEN-1:0] ReadDataW;
  logic [XLEN-1:0] PCPlus4W;
  logic [XLEN-1:0] ImmExtW;
  logic [AW-1:0]   Rs1D;
  logic [AW-1:0]   Rs2D;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ResultW;
  logic [31:0]     WriteCountW;

  // pipeline side: drives the W bundle and read addresses
  modport master (
    output RegWriteW, RdW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, ImmExtW,
    output Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, WriteCountW
  );

  // register file side
  modport slave (
    input  RegWriteW, RdW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, ImmExtW,
    input  Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, WriteCountW
  );

endinterface

// File: rtl/result_mux.sv
// 4:1 W-stage result select; also used by the forwarding path.
module result_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  riscv_pkg::result_src_t sel,
  input  logic [XLEN-1:0]        alu,
  input  logic [XLEN-1:0]        mem,
  input  logic [XLEN-1:0]        pc4,
  input  logic [XLEN-1:0]        imm,
  output logic [XLEN-1:0]        result
);

  import riscv_pkg::*;

  // pick the committed value by source
  always_comb begin
    result = alu;
    unique case (sel)
      RES_ALU: result = alu;
      RES_MEM: result = mem;
      RES_PC4: result = pc4;
      RES_IMM: result = imm;
      default: result = alu;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: result select, 32-entry integer register file, commit counter.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through to the decode read ports.
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  writeback_regfile_if.slave  wb
);

  import riscv_pkg::*;

  logic [XLEN-1:0] result_w;
  logic            commit;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [31:0]     count_q, count_d;
  logic [XLEN-1:0] rd1, rd2;

  result_mux #(.XLEN(XLEN)) u_result_mux (
    .sel    (result_src_t'(wb.ResultSrcW)),
    .alu    (wb.ALUResultW),
    .mem    (wb.ReadDataW),
    .pc4    (wb.PCPlus4W),
    .imm    (wb.ImmExtW),
    .result (result_w)
  );

  // x0 is hardwired, so writes to it neither land nor count
  assign commit = !rst && wb.RegWriteW && (wb.RdW != AW'(REG_ZERO));

  // next-state of the array and counter; counter wraps naturally
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (commit) begin
      regs_d[wb.RdW] = result_w;
      count_d        = count_q + 32'd1;
    end
  end

  // register state, cleared synchronously; a write in the reset cycle is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // read port 1: zero during reset or for x0, otherwise array (or bypassed result)
  always_comb begin
    rd1 = regs_q[wb.Rs1D];
`ifdef REGFILE_BYPASS_EN
    if (commit && wb.RdW == wb.Rs1D) rd1 = result_w;
`endif
    if (rst || wb.Rs1D == AW'(REG_ZERO)) rd1 = '0;
  end

  // read port 2: same rules as port 1
  always_comb begin
    rd2 = regs_q[wb.Rs2D];
`ifdef REGFILE_BYPASS_EN
    if (commit && wb.RdW == wb.Rs2D) rd2 = result_w;
`endif
    if (rst || wb.Rs2D == AW'(REG_ZERO)) rd2 = '0;
  end

  assign wb.RD1D        = rd1;
  assign wb.RD2D        = rd2;
  assign wb.ResultW     = result_w;
  assign wb.WriteCountW = count_q;

endmodule
